// File: rtl/capture_buffer.sv
// capture_buffer: sample buffer for the logic analyzer capture path.
// Two modes of operation:
//   IDLE      plain FIFO (writes dropped when full, sticky overflow flag)
//   PRE/POST  triggered capture: circular pre-trigger history, then a
//             programmable number of post-trigger samples, then DONE
//             (frozen for readout; further writes ignored).
// Optional build macro CAPTURE_BUFFER_STATS_EN adds lost_cnt, a saturating
// count of samples overwritten while capturing.
// Ports:
//   clk, reset_n (sync, active-low), clear (sync flush, rd_data held)
//   wr_en/wr_data            sample input from the sampler
//   rd_en -> rd_data/rd_valid pop with 1-cycle latency
//   arm, trig, post_len      capture control (post_len latched on arm)
//   full, empty, level       occupancy derived from registered pointers
//   state                    0 IDLE, 1 PRE, 2 POST, 3 DONE
//   overflow                 sticky, IDLE write dropped while full
//   lost_cnt                 (CAPTURE_BUFFER_STATS_EN only)
module capture_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              arm,
    input  logic              trig,
    input  logic [ADDR_W:0]   post_len,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic [1:0]        state,
`ifdef CAPTURE_BUFFER_STATS_EN
    output logic [31:0]       lost_cnt,
`endif
    output logic              overflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned PTR_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           st;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] post_len_q;
    logic [PTR_W-1:0] remaining;
    logic [DATA_W-1:0] mem [DEPTH];

    logic capturing;
    logic readable;
    logic arm_go;
    logic wr_go;
    logic rd_go;
    logic overwrite;
    logic [PTR_W-1:0] post_len_clamped;

    // Occupancy straight from the registered pointers; MSB separates full/empty
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == PTR_W'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign state = st;

    // Per-cycle accept decisions; clear and an accepted arm suppress traffic
    assign capturing = (st == ST_PRE) || (st == ST_POST);
    assign readable  = (st == ST_IDLE) || (st == ST_DONE);
    assign arm_go    = arm && readable;
    assign wr_go     = reset_n && !clear && !arm_go && wr_en &&
                       (capturing || ((st == ST_IDLE) && !full));
    assign rd_go     = reset_n && !clear && !arm_go && rd_en && readable && !empty;
    // While capturing a full buffer, the oldest sample is dropped to make room
    assign overwrite = wr_go && capturing && full;
    assign post_len_clamped = (post_len > PTR_W'(DEPTH)) ? PTR_W'(DEPTH) : post_len;

    // Sample storage: plain synchronous RAM, no reset
    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Read port register; clear leaves the last popped sample in place
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_go) begin
            rd_data <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    // Control FSM, pointers and flags
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            st         <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            post_len_q <= '0;
            remaining  <= '0;
            rd_valid   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rd_valid <= rd_go;
            if (arm_go) begin
                // Re-arming discards whatever the buffer held
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                post_len_q <= post_len_clamped;
                st         <= ST_PRE;
            end else begin
                if (wr_go) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (overwrite || rd_go) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if ((st == ST_IDLE) && wr_en && full) begin
                    overflow <= 1'b1;
                end
                case (st)
                    ST_PRE: begin
                        // A write coinciding with trig is still pre-trigger
                        if (trig) begin
                            remaining <= post_len_q;
                            st        <= (post_len_q == '0) ? ST_DONE : ST_POST;
                        end
                    end
                    ST_POST: begin
                        if (wr_go) begin
                            remaining <= remaining - 1'b1;
                            if (remaining == PTR_W'(1)) begin
                                st <= ST_DONE;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef CAPTURE_BUFFER_STATS_EN
    // Saturating count of samples lost to overwrite during capture
    always_ff @(posedge clk) begin
        if (!reset_n || clear || arm_go) begin
            lost_cnt <= '0;
        end else if (overwrite && (lost_cnt != 32'hFFFF_FFFF)) begin
            lost_cnt <= lost_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_capture_buffer.sv
// Self-checking bench for capture_buffer (DATA_W=8, ADDR_W=4, DEPTH=16).
// Expected samples come from a bench-side content queue (mdl) and flow
// through a scoreboard queue (sb) that is popped as rd_valid data appears.
module tb_capture_buffer;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          arm;
    logic          trig;
    logic [AW:0]   post_len;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic [1:0]    state;
    logic          overflow;
`ifdef CAPTURE_BUFFER_STATS_EN
    logic [31:0]   lost_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int lost_exp    = 0;
    logic [DW-1:0] mdl[$];
    logic [DW-1:0] sb[$];

    capture_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .arm      (arm),
        .trig     (trig),
        .post_len (post_len),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .state    (state),
`ifdef CAPTURE_BUFFER_STATS_EN
        .lost_cnt (lost_cnt),
`endif
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 0; wr_en = 0; wr_data = '0; rd_en = 0; arm = 0; trig = 0; post_len = '0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        tick(); tick();
        reset_n = 1;
        vectors++;
        if ({state, level, empty, full, rd_valid, overflow, rd_data} !== {2'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_state: st=%0d lvl=%0d e=%b f=%b v=%b ov=%b d=%h", state, level, empty, full, rd_valid, overflow, rd_data);
        end
    endtask

    task automatic test_fifo();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1; wr_data = DW'(i);
            mdl.push_back(DW'(i));
            tick();
        end
        wr_data = 8'hAA;
        tick();
        wr_en = 0;
        vectors++;
        if ({full, overflow, level} !== {1'b1, 1'b1, 5'd16}) begin
            miscompares++;
            $display("FAIL fifo_full: full=%b ov=%b lvl=%0d want 1 1 16", full, overflow, level);
        end
        for (int i = 0; i < 16; i++) begin
            sb.push_back(mdl.pop_front());
            rd_en = 1;
            tick();
            vectors++;
            if (!rd_valid || sb.size() == 0 || rd_data !== sb.pop_front()) begin
                miscompares++;
                $display("FAIL fifo_pop[%0d]: v=%b got %h want %h", i, rd_valid, rd_data, DW'(i));
            end
        end
        tick();
        rd_en = 0;
        vectors++;
        if ({empty, rd_valid, level} !== {1'b1, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL fifo_empty_pop: e=%b v=%b lvl=%0d want 1 0 0", empty, rd_valid, level);
        end
    endtask

    task automatic test_capture();
        clear = 1; tick(); clear = 0;
        arm = 1; post_len = 5'd4; tick(); arm = 0;
        mdl.delete();
        lost_exp = 0;
        vectors++;
        if ({state, level} !== {2'd1, 5'd0}) begin
            miscompares++;
            $display("FAIL cap_armed: st=%0d lvl=%0d want 1 0", state, level);
        end
        for (int i = 0; i < 26; i++) begin
            wr_en = 1; wr_data = DW'(i); trig = (i == 19);
            if (i < 24) begin
                mdl.push_back(DW'(i));
                if (mdl.size() > DEPTH) begin
                    void'(mdl.pop_front());
                    lost_exp++;
                end
            end
            tick();
            trig = 0;
            if (i == 19 || i == 22 || i == 23) begin
                vectors++;
                if (state !== ((i == 23) ? 2'd3 : 2'd2)) begin
                    miscompares++;
                    $display("FAIL cap_state_after_%h: got %0d want %0d", i, state, (i == 23) ? 3 : 2);
                end
            end
        end
        wr_en = 0;
        vectors++;
        if ({state, level, overflow} !== {2'd3, 5'd16, 1'b0}) begin
            miscompares++;
            $display("FAIL cap_done: st=%0d lvl=%0d ov=%b want 3 16 0", state, level, overflow);
        end
`ifdef CAPTURE_BUFFER_STATS_EN
        vectors++;
        if (lost_cnt !== 32'(lost_exp)) begin
            miscompares++;
            $display("FAIL cap_lost_cnt: got %0d want %0d", lost_cnt, lost_exp);
        end
`endif
        for (int i = 0; i < 16; i++) begin
            sb.push_back(mdl.pop_front());
            rd_en = 1;
            tick();
            vectors++;
            if (!rd_valid || sb.size() == 0 || rd_data !== sb.pop_front()) begin
                miscompares++;
                $display("FAIL cap_read[%0d]: v=%b got %h want %h", i, rd_valid, rd_data, DW'(i + 8));
            end
        end
        rd_en = 0;
        tick();
        vectors++;
        if ({state, empty} !== {2'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL cap_stay_done: st=%0d e=%b want 3 1", state, empty);
        end
    endtask

    task automatic test_post_len_zero();
        arm = 1; post_len = 5'd0; tick(); arm = 0;
        mdl.delete();
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1; wr_data = DW'(i);
            mdl.push_back(DW'(i));
            tick();
        end
        wr_en = 0; trig = 1; tick(); trig = 0;
        vectors++;
        if ({state, level} !== {2'd3, 5'd3}) begin
            miscompares++;
            $display("FAIL pl0_done: st=%0d lvl=%0d want 3 3", state, level);
        end
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mdl.pop_front());
            rd_en = 1;
            tick();
            vectors++;
            if (!rd_valid || sb.size() == 0 || rd_data !== sb.pop_front()) begin
                miscompares++;
                $display("FAIL pl0_read[%0d]: v=%b got %h want %h", i, rd_valid, rd_data, DW'(i + 1));
            end
        end
        rd_en = 0;
    endtask

    // post_len above DEPTH behaves as DEPTH post-trigger samples
    task automatic test_clamp();
        arm = 1; post_len = 5'd20; tick(); arm = 0;
        trig = 1; tick(); trig = 0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1; wr_data = DW'(8'h50 + i);
            tick();
        end
        wr_en = 0;
        vectors++;
        if ({state, level} !== {2'd3, 5'd16}) begin
            miscompares++;
            $display("FAIL clamp_done: st=%0d lvl=%0d want 3 16", state, level);
        end
    endtask

    task automatic test_back_to_back();
        clear = 1; tick(); clear = 0;
        mdl.delete();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1; wr_data = DW'(8'h30 + i);
            mdl.push_back(wr_data);
            tick();
        end
        wr_data = 8'h35; rd_en = 1;
        mdl.push_back(wr_data);
        sb.push_back(mdl.pop_front());
        tick();
        wr_en = 0; rd_en = 0;
        vectors++;
        if (!rd_valid || level !== 5'd5 || sb.size() == 0 || rd_data !== sb.pop_front()) begin
            miscompares++;
            $display("FAIL b2b: v=%b lvl=%0d d=%h want 1 5 30", rd_valid, level, rd_data);
        end
    endtask

    task automatic test_reset_clear();
        clear = 1; tick(); clear = 0;
        arm = 1; post_len = 5'd2; tick(); arm = 0;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1; wr_data = DW'(8'h40 + i); trig = (i == 15);
            tick();
            trig = 0;
        end
        wr_en = 0;
        vectors++;
        if ({state, level} !== {2'd2, 5'd16}) begin
            miscompares++;
            $display("FAIL mid_post: st=%0d lvl=%0d want 2 16", state, level);
        end
        reset_n = 0; tick(); reset_n = 1;
        vectors++;
        if ({state, level, empty, rd_valid} !== {2'd0, 5'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_post: st=%0d lvl=%0d e=%b v=%b want 0 0 1 0", state, level, empty, rd_valid);
        end
        wr_en = 1; wr_data = 8'h77; tick(); wr_en = 0;
        rd_en = 1; tick(); rd_en = 0;
        clear = 1; arm = 1; post_len = 5'd3; tick(); clear = 0; arm = 0;
        vectors++;
        if ({state, level, rd_valid, rd_data} !== {2'd0, 5'd0, 1'b0, 8'h77}) begin
            miscompares++;
            $display("FAIL clear_arm: st=%0d lvl=%0d v=%b d=%h want 0 0 0 77", state, level, rd_valid, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_fifo();
        test_capture();
        test_post_len_zero();
        test_clamp();
        test_back_to_back();
        test_reset_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
